// File: rtl/gpr_demux.sv
// One-to-thirteen registered demultiplexer: the destination chosen by sel
// captures data_in on each edge, and every other destination clears to zero.
module gpr_demux (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  sel,
  input  logic [32:0] data_in,
  output logic [32:0] rA,
  output logic [32:0] rB,
  output logic [32:0] rC,
  output logic [32:0] rD,
  output logic [32:0] rE,
  output logic [32:0] rF,
  output logic [32:0] rG,
  output logic [32:0] rH,
  output logic [32:0] rI,
  output logic [32:0] rJ,
  output logic [32:0] rK,
  output logic [32:0] rL,
  output logic [32:0] rM
);

  localparam int unsigned N_DST = 13;

  logic [N_DST-1:0] w_hit;
  logic [32:0]      r_dst [N_DST];

  // Codes 13..15 leave every hit bit low, so all destinations clear.
  always_comb begin
    w_hit = '0;
    for (int i = 0; i < N_DST; i++) begin
      w_hit[i] = (sel == 4'(i));
    end
  end

  // NOTE: every destination is reset, not just the one that is used, because
  // all outputs must read zero while rst_n is low, independent of clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_DST; i++) begin
        r_dst[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments keep all thirteen updates on the same
      // edge and independent of the order in which the loop visits them.
      for (int i = 0; i < N_DST; i++) begin
        r_dst[i] <= w_hit[i] ? data_in : '0;
      end
    end
  end

  assign rA = r_dst[0];
  assign rB = r_dst[1];
  assign rC = r_dst[2];
  assign rD = r_dst[3];
  assign rE = r_dst[4];
  assign rF = r_dst[5];
  assign rG = r_dst[6];
  assign rH = r_dst[7];
  assign rI = r_dst[8];
  assign rJ = r_dst[9];
  assign rK = r_dst[10];
  assign rL = r_dst[11];
  assign rM = r_dst[12];

endmodule

// File: tb/tb_gpr_demux.sv
// Directed bench for gpr_demux: sel sweeps, a full-width value, a
// mid-cycle sel change, and asynchronous reset behaviour.
module tb_gpr_demux;

  logic        clk;
  logic        rst_n;
  logic [3:0]  sel;
  logic [32:0] data_in;
  logic [32:0] rA, rB, rC, rD, rE, rF, rG, rH, rI, rJ, rK, rL, rM;
  logic [32:0] outs [13];

  int n_pass  = 0;
  int n_total = 0;

  gpr_demux dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sel     (sel),
    .data_in (data_in),
    .rA      (rA),
    .rB      (rB),
    .rC      (rC),
    .rD      (rD),
    .rE      (rE),
    .rF      (rF),
    .rG      (rG),
    .rH      (rH),
    .rI      (rI),
    .rJ      (rJ),
    .rK      (rK),
    .rL      (rL),
    .rM      (rM)
  );

  assign outs[0]  = rA;
  assign outs[1]  = rB;
  assign outs[2]  = rC;
  assign outs[3]  = rD;
  assign outs[4]  = rE;
  assign outs[5]  = rF;
  assign outs[6]  = rG;
  assign outs[7]  = rH;
  assign outs[8]  = rI;
  assign outs[9]  = rJ;
  assign outs[10] = rK;
  assign outs[11] = rL;
  assign outs[12] = rM;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected: output idx holds val, all others zero; idx >= 13 means all zero.
  task automatic check_all(input string tag, input int idx, input logic [32:0] val);
    logic [32:0] exp;
    for (int k = 0; k < 13; k++) begin
      exp = (k == idx) ? val : 33'd0;
      n_total++;
      assert (outs[k] === exp) n_pass++;
      else $error("FAIL %s out%0d observed=%h expected=%h", tag, k, outs[k], exp);
    end
  endtask

  // Drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic [3:0] s, input logic [32:0] d);
    @(negedge clk);
    sel     = s;
    data_in = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n   = 1'b0;
    sel     = 4'd0;
    data_in = 33'd501;
    #2;
    check_all("reset_initial", 13, 33'd0);
    @(posedge clk);
    #1;
    check_all("reset_over_edge", 13, 33'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 16; k++) begin
      step(4'(k), 33'd501);
      check_all($sformatf("sweep501_sel%0d", k), k, 33'd501);
    end

    for (int k = 0; k < 16; k++) begin
      step(4'(k), 33'd502);
      check_all($sformatf("sweep502_sel%0d", k), k, 33'd502);
    end

    step(4'd5, 33'h1_FFFF_FFFF);
    check_all("full_width_rF", 5, 33'h1_FFFF_FFFF);
    step(4'd12, 33'h1_0000_0000);
    check_all("bit32_only_rM", 12, 33'h1_0000_0000);
    step(4'd7, 33'd0);
    check_all("zero_data", 13, 33'd0);

    // Mid-cycle sel change: the earlier sel must never be captured.
    step(4'd15, 33'd0);
    @(negedge clk);
    sel     = 4'd2;
    data_in = 33'd7;
    #2;
    sel = 4'd3;
    #1;
    check_all("midcycle_before_edge", 13, 33'd0);
    @(posedge clk);
    #1;
    check_all("midcycle_after_edge", 3, 33'd7);

    // Asynchronous reset between edges, then held across a pending capture.
    step(4'd12, 33'd501);
    check_all("load_rM", 12, 33'd501);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_reset_immediate", 13, 33'd0);
    @(negedge clk);
    sel     = 4'd0;
    data_in = 33'd501;
    @(posedge clk);
    #1;
    check_all("reset_discards_capture", 13, 33'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all("first_edge_after_reset", 0, 33'd501);
    step(4'd1, 33'd3);
    check_all("post_reset_rB", 1, 33'd3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/gpr_demux.md
GPR_DEMUX -- requirements
Module: gpr_demux

Interface
REQ-001 The module SHALL have one clock and one reset; the reset is asynchronous and active-low.
REQ-002 Port clk: input, 1 bit, system clock; all state updates occur on its rising edge.
REQ-003 Port rst_n: input, 1 bit, asynchronous active-low reset.
REQ-004 Port sel: input, 4 bits, destination register select code.
REQ-005 Port data_in: input, 33 bits, value to be steered to the selected destination.
REQ-006 Ports rA, rB, rC, rD, rE, rF, rG, rH, rI, rJ, rK, rL, rM: outputs, 33 bits each, registered per-destination data.
REQ-007 The module SHALL have no parameters; all widths are fixed at the values above.

Function
REQ-008 Decode map SHALL be: sel=0 -> rA, 1 -> rB, 2 -> rC, 3 -> rD, 4 -> rE, 5 -> rF, 6 -> rG, 7 -> rH, 8 -> rI, 9 -> rJ, 10 -> rK, 11 -> rL, 12 -> rM.
REQ-009 On each rising clk edge with rst_n high, the output mapped by sel SHALL load data_in, all 33 bits unmodified.
REQ-010 On that same edge, every non-selected output SHALL load 33'd0; outputs do not hold prior values.
REQ-011 For sel = 13, 14 or 15, all thirteen outputs SHALL load 33'd0 on the edge.
REQ-012 Latency SHALL be exactly one clk cycle from a stable sel/data_in to the updated outputs.
REQ-013 No combinational path SHALL exist from sel or data_in to any output.
REQ-014 At most one output SHALL be non-zero after any edge; data_in = 0 yields all outputs zero.
REQ-015 data_in SHALL be passed without sign extension, truncation or arithmetic; bit 32 is carried like any other bit.
REQ-016 A sel change between edges SHALL have no effect until the next rising edge.
REQ-017 There is no handshake; the module SHALL accept new sel/data_in every cycle.

Reset
REQ-018 While rst_n is low, all thirteen outputs SHALL be 33'd0 immediately, independent of clk.
REQ-019 Reset asserted mid-operation SHALL clear all outputs asynchronously and discard the pending capture.
REQ-020 On the first rising edge after rst_n deasserts, normal operation per REQ-009 to REQ-011 SHALL apply.

Verification
REQ-021 Sweep with data_in=501: sel = 0..15, one edge each -> after edge k (k<=12) only output k = 501, all others 0; sel 13..15 -> all outputs 0.
REQ-022 Repeat the sweep with data_in=502 -> same pattern with 502; no residue of 501 on any output.
REQ-023 sel=5, data_in=33'h1_FFFF_FFFF -> rF = 33'h1_FFFF_FFFF after one edge, all other outputs 0.
REQ-024 Load rM with 501, then pull rst_n low between edges -> all outputs 0 at once, without waiting for a clock edge.
REQ-025 Change sel from 2 to 3 mid-cycle with data_in=7 -> outputs change only at the next edge; rD = 7, rC = 0.
